// File: rtl/dmem_io_responder_if.sv
// Data-memory bus between the single-cycle CPU (master) and the memory/IO responder (slave).
// Reads are combinational, so ddata is valid in the same cycle as daddr/dread.
interface dmem_io_responder_if;
    logic [15:0] daddr;
    logic        dwrite;
    logic        dread;
    logic [15:0] dwdata;
    logic [15:0] ddata;

    modport master (output daddr, output dwrite, output dread, output dwdata, input ddata);
    modport slave  (input daddr, input dwrite, input dread, input dwdata, output ddata);
endinterface

// File: rtl/dmem_io_responder.sv
// Data RAM plus memory-mapped LED, synchronized switches and interval timer on the CPU data bus.
// Optional macro DMEM_BUSERR_EN enables the sticky unmapped-access detector driving bus_err.
module dmem_io_responder #(
    parameter int          DEPTH   = 128,
    parameter logic [15:0] IO_BASE = 16'hFFF0
) (
    input  logic                      clock,
    input  logic                      reset,
    dmem_io_responder_if.slave        bus,
    input  logic [15:0]               sw_in,
    output logic [15:0]               led_out,
    output logic                      timer_irq,
    output logic                      bus_err
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] OFF_LED  = 3'd0;
    localparam logic [2:0] OFF_SW   = 3'd1;
    localparam logic [2:0] OFF_CNT  = 3'd2;
    localparam logic [2:0] OFF_PER  = 3'd3;
    localparam logic [2:0] OFF_CTRL = 3'd4;

    logic [15:0] mem_q [DEPTH];

    logic [15:0] led_q, led_d;
    logic [15:0] sw_s1_q, sw_s1_d;
    logic [15:0] sw_s2_q, sw_s2_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] per_q, per_d;
    logic        en_q, en_d;
    logic        exp_q, exp_d;

    logic        ram_hit;
    logic        io_hit;
    logic [2:0]  io_off;
    logic [AW-1:0] ram_idx;
    logic        wr_led, wr_cnt, wr_per, wr_ctrl;
    logic        exp_set;
    logic [15:0] rdata;

    assign ram_hit = 32'(bus.daddr) < DEPTH;
    assign io_hit  = bus.daddr[15:3] == IO_BASE[15:3];
    assign io_off  = bus.daddr[2:0];
    assign ram_idx = bus.daddr[AW-1:0];

    assign wr_led  = bus.dwrite && io_hit && (io_off == OFF_LED);
    assign wr_cnt  = bus.dwrite && io_hit && (io_off == OFF_CNT);
    assign wr_per  = bus.dwrite && io_hit && (io_off == OFF_PER);
    assign wr_ctrl = bus.dwrite && io_hit && (io_off == OFF_CTRL);

    always_comb begin
        rdata = 16'h0000;
        if (ram_hit) begin
            rdata = mem_q[ram_idx];
        end else if (io_hit) begin
            case (io_off)
                OFF_LED:  rdata = led_q;
                OFF_SW:   rdata = sw_s2_q;
                OFF_CNT:  rdata = cnt_q;
                OFF_PER:  rdata = per_q;
                OFF_CTRL: rdata = {14'b0, exp_q, en_q};
                default:  rdata = 16'h0000;
            endcase
        end
    end

    assign bus.ddata = bus.dread ? rdata : 16'h0000;

    // A CPU write to CNT overrides the count/reload and suppresses EXP for that cycle.
    always_comb begin
        led_d   = led_q;
        sw_s1_d = sw_in;
        sw_s2_d = sw_s1_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        en_d    = en_q;
        exp_set = 1'b0;

        if (wr_cnt) begin
            cnt_d = bus.dwdata;
        end else if (en_q) begin
            if (cnt_q == per_q) begin
                cnt_d   = 16'h0000;
                exp_set = 1'b1;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end

        if (wr_led)  led_d = bus.dwdata;
        if (wr_per)  per_d = bus.dwdata;
        if (wr_ctrl) en_d  = bus.dwdata[0];

        exp_d = exp_q;
        if (wr_ctrl && bus.dwdata[1]) exp_d = 1'b0;
        if (exp_set)                  exp_d = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            led_q   <= 16'h0000;
            sw_s1_q <= 16'h0000;
            sw_s2_q <= 16'h0000;
            cnt_q   <= 16'h0000;
            per_q   <= 16'hFFFF;
            en_q    <= 1'b0;
            exp_q   <= 1'b0;
        end else begin
            led_q   <= led_d;
            sw_s1_q <= sw_s1_d;
            sw_s2_q <= sw_s2_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            en_q    <= en_d;
            exp_q   <= exp_d;
        end
    end

    // RAM has no reset so its contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (bus.dwrite && ram_hit) begin
            mem_q[ram_idx] <= bus.dwdata;
        end
    end

    assign led_out   = led_q;
    assign timer_irq = exp_q;

`ifdef DMEM_BUSERR_EN
    logic bus_err_q, bus_err_d;
    logic io_mapped;

    assign io_mapped = io_hit && (io_off <= OFF_CTRL);

    always_comb begin
        bus_err_d = bus_err_q;
        if ((bus.dread || bus.dwrite) && !ram_hit && !io_mapped) bus_err_d = 1'b1;
        if (bus.dwrite && io_hit && (io_off == OFF_SW))          bus_err_d = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_io_responder.sv
// Self-checking bench for dmem_io_responder: directed scenarios then randomized bus traffic
// checked against a behavioural memory-map model.
module tb_dmem_io_responder;

    localparam int          DEPTH   = 128;
    localparam logic [15:0] IO_BASE = 16'hFFF0;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] sw_in = 16'h0000;
    logic [15:0] led_out;
    logic        timer_irq;
    logic        bus_err;

    dmem_io_responder_if bus ();

    dmem_io_responder #(.DEPTH(DEPTH), .IO_BASE(IO_BASE)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .sw_in     (sw_in),
        .led_out   (led_out),
        .timer_irq (timer_irq),
        .bus_err   (bus_err)
    );

    always #5 clock = ~clock;

`ifdef DMEM_BUSERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model of the visible memory map
    logic [15:0] m_ram [DEPTH];
    bit          m_valid [DEPTH];
    logic [15:0] m_led, m_s1, m_s2, m_cnt, m_per;
    bit          m_en, m_exp, m_err;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int io_offset(input logic [15:0] a);
        if (int'(a) >= int'(IO_BASE) && int'(a) < int'(IO_BASE) + 8) return int'(a) - int'(IO_BASE);
        return -1;
    endfunction

    function automatic bit m_known(input logic [15:0] a);
        if (int'(a) < DEPTH) return m_valid[int'(a)];
        return 1'b1;
    endfunction

    function automatic logic [15:0] m_value(input logic [15:0] a);
        int off;
        if (int'(a) < DEPTH) return m_ram[int'(a)];
        off = io_offset(a);
        case (off)
            0: return m_led;
            1: return m_s2;
            2: return m_cnt;
            3: return m_per;
            4: return {14'b0, m_exp, m_en};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic m_reset();
        m_led = 16'h0000; m_s1 = 16'h0000; m_s2 = 16'h0000;
        m_cnt = 16'h0000; m_per = 16'hFFFF;
        m_en = 1'b0; m_exp = 1'b0; m_err = 1'b0;
    endtask

    task automatic m_edge();
        logic [15:0] a, wd, n_cnt;
        bit w, r, set_exp, in_ram;
        int off;
        a = bus.daddr; wd = bus.dwdata; w = bus.dwrite; r = bus.dread;
        off = io_offset(a);
        in_ram = int'(a) < DEPTH;
        n_cnt = m_cnt;
        set_exp = 1'b0;
        if (w && off == 2) n_cnt = wd;
        else if (m_en) begin
            if (m_cnt == m_per) begin n_cnt = 16'h0000; set_exp = 1'b1; end
            else n_cnt = m_cnt + 16'd1;
        end
        if (w && off == 4 && wd[1]) m_exp = 1'b0;
        if (set_exp) m_exp = 1'b1;
        if (w && off == 4) m_en = wd[0];
        if (w && off == 3) m_per = wd;
        if (w && off == 0) m_led = wd;
        if (w && in_ram) begin m_ram[int'(a)] = wd; m_valid[int'(a)] = 1'b1; end
        if (ERR_EN && (r || w) && !in_ram && !(off >= 0 && off <= 4)) m_err = 1'b1;
        if (ERR_EN && w && off == 1) m_err = 1'b1;
        m_s2 = m_s1;
        m_s1 = sw_in;
        m_cnt = n_cnt;
    endtask

    task automatic set_bus(input logic [15:0] a, input bit w, input bit r, input logic [15:0] d);
        bus.daddr = a; bus.dwrite = w; bus.dread = r; bus.dwdata = d;
    endtask

    // Check the combinational read, take one edge, then check registered outputs.
    task automatic cyc();
        #1;
        if (bus.dread) begin
            if (m_known(bus.daddr)) chk("ddata", bus.ddata, m_value(bus.daddr));
        end else begin
            chk("ddata_idle", bus.ddata, 16'h0000);
        end
        @(posedge clock);
        m_edge();
        #1;
        chk("led_out", led_out, m_led);
        chk("timer_irq", {15'b0, timer_irq}, {15'b0, m_exp});
        chk("bus_err", {15'b0, bus_err}, {15'b0, m_err});
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin m_valid[i] = 1'b0; m_ram[i] = 16'h0000; end
        m_reset();
        set_bus(16'h0000, 1'b0, 1'b0, 16'h0000);

        // Reset values while reset is held
        #12;
        chk("rst_led", led_out, 16'h0000);
        chk("rst_irq", {15'b0, timer_irq}, 16'h0000);
        chk("rst_err", {15'b0, bus_err}, 16'h0000);
        set_bus(IO_BASE + 16'd3, 1'b0, 1'b1, 16'h0000);
        #1 chk("rst_per", bus.ddata, 16'hFFFF);
        set_bus(IO_BASE + 16'd2, 1'b0, 1'b1, 16'h0000);
        #1 chk("rst_cnt", bus.ddata, 16'h0000);
        set_bus(16'h0000, 1'b0, 1'b0, 16'h0000);
        @(negedge clock) reset = 1'b1;

        // 1: RAM write then zero-latency read
        set_bus(16'd5, 1'b1, 1'b0, 16'hBEEF); cyc();
        set_bus(16'd5, 1'b0, 1'b1, 16'h0000);
        #1 chk("t1_ram5", bus.ddata, 16'hBEEF);
        cyc();
        set_bus(16'd5, 1'b0, 1'b0, 16'h0000);
        #1 chk("t1_noread", bus.ddata, 16'h0000);
        // read-during-write returns old value
        set_bus(16'd7, 1'b1, 1'b0, 16'h1111); cyc();
        set_bus(16'd7, 1'b1, 1'b1, 16'h2222);
        #1 chk("t1_rdw_old", bus.ddata, 16'h1111);
        cyc();
        set_bus(16'd7, 1'b0, 1'b1, 16'h0000);
        #1 chk("t1_rdw_new", bus.ddata, 16'h2222);
        cyc();

        // 2: LED register and switch synchronizer latency
        set_bus(IO_BASE, 1'b1, 1'b0, 16'h00A5); cyc();
        chk("t2_led", led_out, 16'h00A5);
        sw_in = 16'h1234;
        set_bus(IO_BASE + 16'd1, 1'b0, 1'b1, 16'h0000); cyc();
        chk("t2_sw_1st", bus.ddata, 16'h0000);
        cyc();
        chk("t2_sw_2nd", bus.ddata, 16'h1234);

        // 3: timer period 3
        set_bus(IO_BASE + 16'd3, 1'b1, 1'b0, 16'd3); cyc();
        set_bus(IO_BASE + 16'd4, 1'b1, 1'b0, 16'd1); cyc();
        set_bus(IO_BASE + 16'd2, 1'b0, 1'b1, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            #1 chk("t3_cnt", bus.ddata, 16'(i));
            chk("t3_irq_low", {15'b0, timer_irq}, 16'h0000);
            cyc();
        end
        chk("t3_irq", {15'b0, timer_irq}, 16'h0001);
        chk("t3_wrap", bus.ddata, 16'h0000);
        set_bus(IO_BASE + 16'd4, 1'b1, 1'b0, 16'd3); cyc();
        chk("t3_irq_clr", {15'b0, timer_irq}, 16'h0000);
        set_bus(IO_BASE + 16'd4, 1'b0, 1'b1, 16'h0000);
        #1 chk("t3_ctrl", bus.ddata, 16'h0001);
        cyc();

        // 4: clear collides with reload; CNT write wins over counting
        set_bus(IO_BASE + 16'd2, 1'b0, 1'b1, 16'h0000);
        #1 chk("t4_cnt2", bus.ddata, 16'd2);
        cyc();
        set_bus(IO_BASE + 16'd4, 1'b1, 1'b0, 16'd3); cyc();
        chk("t4_set_wins", {15'b0, timer_irq}, 16'h0001);
        set_bus(IO_BASE + 16'd2, 1'b1, 1'b0, 16'h0010); cyc();
        set_bus(IO_BASE + 16'd2, 1'b0, 1'b1, 16'h0000);
        #1 chk("t4_cnt_wr", bus.ddata, 16'h0010);
        cyc();

        // 5: reset mid-count at CNT=2
        set_bus(IO_BASE + 16'd2, 1'b1, 1'b0, 16'd1); cyc();
        set_bus(IO_BASE + 16'd2, 1'b0, 1'b1, 16'h0000); cyc();
        #1 chk("t5_cnt2", bus.ddata, 16'd2);
        reset = 1'b0;
        m_reset();
        #1;
        chk("t5_cnt", bus.ddata, 16'h0000);
        chk("t5_led", led_out, 16'h0000);
        chk("t5_irq", {15'b0, timer_irq}, 16'h0000);
        chk("t5_err", {15'b0, bus_err}, 16'h0000);
        set_bus(IO_BASE + 16'd4, 1'b0, 1'b1, 16'h0000);
        #1 chk("t5_ctrl", bus.ddata, 16'h0000);
        set_bus(IO_BASE + 16'd1, 1'b0, 1'b1, 16'h0000);
        #1 chk("t5_sw", bus.ddata, 16'h0000);
        set_bus(16'd5, 1'b0, 1'b1, 16'h0000);
        #1 chk("t5_ram5", bus.ddata, 16'hBEEF);
        @(negedge clock) reset = 1'b1;
        cyc();

        // 6: unmapped access
        set_bus(16'h4000, 1'b0, 1'b1, 16'h0000);
        #1 chk("t6_ddata", bus.ddata, 16'h0000);
        cyc();
        chk("t6_err", {15'b0, bus_err}, {15'b0, ERR_EN});
        set_bus(16'h0000, 1'b0, 1'b0, 16'h0000); cyc();
        chk("t6_err_hold", {15'b0, bus_err}, {15'b0, ERR_EN});

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [15:0] a, d;
            int kind;
            kind = $urandom_range(0, 9);
            if (kind < 5)       a = 16'($urandom_range(0, DEPTH - 1));
            else if (kind < 9)  a = IO_BASE + 16'($urandom_range(0, 7));
            else                a = 16'h0080 + 16'($urandom_range(0, 16'h7F00));
            if (io_offset(a) == 2 || io_offset(a) == 3) d = 16'($urandom_range(0, 6));
            else d = 16'($urandom);
            if ($urandom_range(0, 7) == 0) sw_in = 16'($urandom);
            set_bus(a, 1'($urandom), 1'($urandom), d);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
